// File: rtl/sha256_bus_master.sv
// Host-side initiator for one SHA-256 register peripheral: loads a 3-byte message, starts, polls, returns digest.
// Define SHA256_MASTER_TIMEOUT_EN to bound status polling to POLL_TIMEOUT reads and flag err on expiry.
module sha256_bus_master #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned POLL_INTERVAL = 8,
  parameter int unsigned POLL_TIMEOUT  = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [23:0]  cmd_msg,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig,
  output logic         err,
  output logic         sha_reset_n,
  output logic [5:0]   address,
  output logic         wren,
  output logic         rden,
  output logic [31:0]  write_reg,
  input  logic [31:0]  read_reg
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > POLL_INTERVAL)
                                    ? ((RST_CYCLES > 8) ? RST_CYCLES : 8)
                                    : ((POLL_INTERVAL > 8) ? POLL_INTERVAL : 8);
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE,
    RST,
    SETTLE,
    WR_DATA,
    WR_CTRL,
    POLL_RD,
    POLL_CHK,
    RD_DIG,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [23:0]   msg;
  logic          accept;
  logic          poll_expired;
  logic          timeout_hit;

  logic          sha_reset_n_nxt;
  logic          wren_nxt, rden_nxt;
  logic [5:0]    address_nxt;
  logic [31:0]   write_reg_nxt;

  assign accept      = (state == IDLE) && cmd_valid && cmd_ready;
  assign timeout_hit = (state == POLL_RD) && !read_reg[0] && poll_expired;

`ifdef SHA256_MASTER_TIMEOUT_EN
  localparam int unsigned PW = ($clog2(POLL_TIMEOUT + 1) > 13) ? $clog2(POLL_TIMEOUT + 1) : 13;

  logic [PW-1:0] poll_cnt;
  logic          err_q;

  // poll_cnt holds completed status reads, so the read in flight is number poll_cnt+1
  assign poll_expired = (poll_cnt >= PW'(POLL_TIMEOUT - 1));
  assign err          = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        poll_cnt <= '0;
        err_q    <= 1'b0;
      end else if (state == POLL_RD) begin
        if (poll_cnt != '1) poll_cnt <= poll_cnt + PW'(1);
        if (timeout_hit) err_q <= 1'b1;
      end
    end
  end
`else
  assign poll_expired = 1'b0;
  assign err          = 1'b0;
`endif

  // Status is judged on the edge that ends the POLL_RD cycle; POLL_CHK only spaces the next read.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) state_nxt = RST;
      end
      RST: begin
        if (cnt == CW'(RST_CYCLES - 1)) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (cnt == CW'(1)) begin
          state_nxt = WR_DATA;
          cnt_nxt   = '0;
        end
      end
      WR_DATA: begin
        if (cnt == CW'(1)) begin
          state_nxt = WR_CTRL;
          cnt_nxt   = '0;
        end
      end
      WR_CTRL: begin
        if (cnt == CW'(1)) begin
          state_nxt = POLL_RD;
          cnt_nxt   = '0;
        end
      end
      POLL_RD: begin
        cnt_nxt = '0;
        if (read_reg[0])           state_nxt = RD_DIG;
        else if (timeout_hit)      state_nxt = DONE;
        else if (POLL_INTERVAL != 0) state_nxt = POLL_CHK;
      end
      POLL_CHK: begin
        if (POLL_INTERVAL <= 1 || cnt == CW'(POLL_INTERVAL - 1)) begin
          state_nxt = POLL_RD;
          cnt_nxt   = '0;
        end
      end
      RD_DIG: begin
        if (cnt == CW'(7)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end
      end
      DONE: begin
        cnt_nxt = '0;
        if (dig_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Bus outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    sha_reset_n_nxt = sha_reset_n;
    wren_nxt        = 1'b0;
    rden_nxt        = 1'b0;
    address_nxt     = '0;
    write_reg_nxt   = '0;
    if (state_nxt == RST)       sha_reset_n_nxt = 1'b0;
    else if (state_nxt != IDLE) sha_reset_n_nxt = 1'b1;
    case (state_nxt)
      WR_DATA: begin
        wren_nxt      = 1'b1;
        address_nxt   = 6'd8;
        write_reg_nxt = {8'h00, msg};
      end
      WR_CTRL: begin
        wren_nxt      = 1'b1;
        address_nxt   = 6'd0;
        write_reg_nxt = 32'h1;
      end
      POLL_RD: begin
        rden_nxt    = 1'b1;
        address_nxt = 6'd4;
      end
      RD_DIG: begin
        rden_nxt    = 1'b1;
        address_nxt = {4'(cnt_nxt[2:0]) + 4'd3, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      msg         <= '0;
      dig         <= '0;
      cmd_ready   <= 1'b0;
      dig_valid   <= 1'b0;
      sha_reset_n <= 1'b0;
      wren        <= 1'b0;
      rden        <= 1'b0;
      address     <= '0;
      write_reg   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cmd_ready   <= (state_nxt == IDLE);
      dig_valid   <= (state_nxt == DONE);
      sha_reset_n <= sha_reset_n_nxt;
      wren        <= wren_nxt;
      rden        <= rden_nxt;
      address     <= address_nxt;
      write_reg   <= write_reg_nxt;
      if (accept) begin
        msg <= cmd_msg;
        dig <= '0;
      end
      if (state == RD_DIG) begin
        for (int unsigned k = 0; k < 8; k++) begin
          if (cnt[2:0] == k[2:0]) dig[255 - 32*k -: 32] <= read_reg;
        end
      end
    end
  end

endmodule
